// File: rtl/alu_div_seq_if.sv
// Request/response and shared-ALU bus for alu_div_seq.
// slave = divider side, master = requester plus the shared ALU.
interface alu_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             alu_own;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_aluc;
  logic [WIDTH-1:0] alu_r;
  logic             alu_carry;

  modport slave (
    input  start, is_signed,
    input  dividend, divisor,
    output busy, done,
    output quotient, remainder,
    output div_by_zero,
    output alu_own, alu_a,
    output alu_b, alu_aluc,
    input  alu_r, alu_carry
  );

  modport master (
    output start, is_signed,
    output dividend, divisor,
    input  busy, done,
    input  quotient, remainder,
    input  div_by_zero,
    input  alu_own, alu_a,
    input  alu_b, alu_aluc,
    output alu_r, alu_carry
  );
endinterface

// File: rtl/alu_div_seq.sv
// Multi-cycle DIV/DIVU sequencer: restoring division on the shared ALU.
// Ports: clk, rst_n (async low), bus (alu_div_seq_if.slave).
module alu_div_seq #(
  parameter int         WIDTH     = 32,
  parameter logic [3:0] ALUC_SUBU = 4'b0001
) (
  input logic          clk,
  input logic          rst_n,
  alu_div_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    NEG_A,
    NEG_B,
    ITER,
    FIX_Q,
    FIX_R,
    DONE
  } state_t;

  state_t st;
  state_t st_nx;
  state_t acc_nx;

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             sa;
  logic             sb;
  logic             sgn;
  logic             dbz;

  logic             accept;
  logic             zdiv;
  logic             last;
  logic [WIDTH-1:0] sh;
  logic             qb;

  assign accept = bus.start &
                  ((st == IDLE) | (st == DONE));
  assign zdiv   = (bus.divisor == '0);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign sh     = {rem[WIDTH-2:0], quo[WIDTH-1]};
  // rem msb set: the 33-bit partial remainder
  // exceeds dvs, so the 32-bit difference is exact.
  assign qb     = rem[WIDTH-1] | ~bus.alu_carry;

  always_comb begin
    acc_nx = ITER;
    if (zdiv)
      acc_nx = DONE;
    else if (bus.is_signed)
      acc_nx = NEG_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      st <= IDLE;
    else
      st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:  if (accept) st_nx = acc_nx;
      NEG_A: st_nx = NEG_B;
      NEG_B: st_nx = ITER;
      ITER:  if (last) st_nx = sgn ? FIX_Q : DONE;
      FIX_Q: st_nx = FIX_R;
      FIX_R: st_nx = DONE;
      DONE:  st_nx = accept ? acc_nx : IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (st != IDLE) & (st != DONE);
    bus.alu_own     = bus.busy;
    bus.done        = (st == DONE);
    bus.quotient    = quo;
    bus.remainder   = rem;
    bus.div_by_zero = dbz;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_aluc    = 4'b0000;
    unique case (st)
      NEG_A: begin
        bus.alu_aluc = ALUC_SUBU;
        bus.alu_b    = quo;
      end
      NEG_B: begin
        bus.alu_aluc = ALUC_SUBU;
        bus.alu_b    = dvs;
      end
      ITER: begin
        bus.alu_aluc = ALUC_SUBU;
        bus.alu_a    = sh;
        bus.alu_b    = dvs;
      end
      FIX_Q: begin
        bus.alu_aluc = ALUC_SUBU;
        bus.alu_b    = quo;
      end
      FIX_R: begin
        bus.alu_aluc = ALUC_SUBU;
        bus.alu_b    = rem;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
      sa  <= 1'b0;
      sb  <= 1'b0;
      sgn <= 1'b0;
      dbz <= 1'b0;
    end else if (accept) begin
      sa  <= bus.dividend[WIDTH-1] & bus.is_signed;
      sb  <= bus.divisor[WIDTH-1] & bus.is_signed;
      sgn <= bus.is_signed;
      dvs <= bus.divisor;
      cnt <= '0;
      // Zero divisor skips straight to DONE,
      // so load the final results here.
      if (zdiv) begin
        quo <= '1;
        rem <= bus.dividend;
        dbz <= 1'b1;
      end else begin
        quo <= bus.dividend;
        rem <= '0;
        dbz <= 1'b0;
      end
    end else begin
      unique case (st)
        NEG_A: if (sa) quo <= bus.alu_r;
        NEG_B: if (sb) dvs <= bus.alu_r;
        ITER: begin
          rem <= qb ? bus.alu_r : sh;
          quo <= {quo[WIDTH-2:0], qb};
          cnt <= cnt + 1'b1;
        end
        FIX_Q: if (sa ^ sb) quo <= bus.alu_r;
        FIX_R: if (sa) rem <= bus.alu_r;
        default: ;
      endcase
    end
  end

endmodule
